acc_line_packer: RTL

- Downstream consumer of the column accumulator's per-line readout. It takes 512 accumulated 20-bit samples per column.
- Each sample is normalised by the iteration count with a power-of-two shift, then saturated to 16 bits.
- Samples are stored in a ping-pong line buffer.
- Each line is streamed to the host/transmit interface as a header word followed by 512 data words, under a valid/ready handshake.

---
 rtl/acc_pkg.sv | 51 +++++
 rtl/line_bank_ram.sv | 32 +++
 rtl/acc_line_packer.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/acc_pkg.sv
// ---------------------------------------------------------------------------
// acc_pkg
// Shared constants, FSM state types and arithmetic helpers for the column
// accumulator line packer.
//   IN_W / OUT_W   : accumulated and normalised sample widths
//   LINE_LEN       : samples per line (one RAM bank)
//   LINE_AW        : address width within one bank
//   HDR_MARK       : fixed marker in the upper byte of each header word
// ---------------------------------------------------------------------------
package acc_pkg;

  localparam int         IN_W     = 20;
  localparam int         OUT_W    = 16;
  localparam int         LINE_LEN = 512;
  localparam int         LINE_AW  = 9;
  localparam logic [7:0] HDR_MARK = 8'hA5;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_FILL = 1'b1
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_HDR  = 2'd1,
    R_DATA = 2'd2
  } rd_state_t;

  // floor(log2(iter + 1)): position of the highest set bit of the
  // iteration count N, so that dividing by 2**shift never exceeds N.
  function automatic logic [2:0] iter_shift(input logic [5:0] iter);
    logic [6:0] n;
    logic [2:0] s;
    n = {1'b0, iter} + 7'd1;
    s = 3'd0;
    for (int i = 1; i < 7; i++) begin
      if (n[i]) s = 3'(i);
    end
    return s;
  endfunction

  // Logical right shift followed by unsigned saturation to OUT_W bits.
  function automatic logic [OUT_W-1:0] norm_sat(input logic [IN_W-1:0] acc,
                                               input logic [2:0]      sh);
    logic [IN_W-1:0] v;
    v = acc >> sh;
    if (|v[IN_W-1:OUT_W]) return '1;
    return v[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/line_bank_ram.sv
// ---------------------------------------------------------------------------
// line_bank_ram
// Simple dual-port RAM (one write port, one read port) with a registered
// read. The top address bit selects the ping-pong bank. The read register
// only updates when i_re is high, so a fetched word is held until the
// consumer is ready for the next one.
//   i_clk   : clock
//   i_we    : write enable        i_waddr / i_wdata : write address / data
//   i_re    : read enable         i_raddr           : read address
//   o_rdata : read data, valid the cycle after i_re
// ---------------------------------------------------------------------------
module line_bank_ram #(
  parameter int AW = 10,
  parameter int W  = 16
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [2**AW];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/acc_line_packer.sv
// ---------------------------------------------------------------------------
// acc_line_packer
// Takes LINE_LEN accumulated samples per column line, normalises each one
// by a power-of-two shift derived from the iteration count, saturates to
// OUT_W bits and stores it into one half of a ping-pong line buffer. Each
// completed line is streamed out as a header word {HDR_MARK, column}
// followed by LINE_LEN sample words under a valid/ready handshake.
//   ClockFromGen  : clock               Reset        : sync active-high
//   DataAccIn     : accumulated sample  DataAccStrobe: sample valid
//   LineStart     : first sample of line ColumnIn / IterCount: line info
//   OutData/OutValid/OutReady           : output stream
//   OutFirst      : header word flag    OutLast      : final sample flag
//   DropCount     : lines dropped, no free bank (saturating)
//   TruncCount    : lines aborted by an early LineStart (saturating)
// ---------------------------------------------------------------------------
module acc_line_packer
  import acc_pkg::*;
(
  input  logic             ClockFromGen,
  input  logic             Reset,
  input  logic [IN_W-1:0]  DataAccIn,
  input  logic             DataAccStrobe,
  input  logic             LineStart,
  input  logic [7:0]       ColumnIn,
  input  logic [5:0]       IterCount,
  output logic [OUT_W-1:0] OutData,
  output logic             OutValid,
  input  logic             OutReady,
  output logic             OutFirst,
  output logic             OutLast,
  output logic [7:0]       DropCount,
  output logic [7:0]       TruncCount
);

  localparam logic [LINE_AW-1:0] LAST_ADDR = LINE_AW'(LINE_LEN - 1);

  // write side
  wr_state_t          r_wstate;
  logic [LINE_AW-1:0] r_wr_addr;
  logic               r_wr_bank;
  logic [2:0]         r_shift;
  logic [7:0]         r_drop_cnt;
  logic [7:0]         r_trunc_cnt;
  logic               r_newer_bank;

  // read side
  rd_state_t          r_rstate;
  logic               r_rd_bank;
  logic [LINE_AW:0]   r_rd_addr;     // next bank address to fetch, 0..LINE_LEN
  logic               r_q_valid;     // RAM read register holds an unsent sample
  logic               r_q_last;      // ... and that sample is the final one
  logic [OUT_W-1:0]   r_out_data;
  logic               r_out_valid;
  logic               r_out_first;
  logic               r_out_last;

  logic [1:0]         w_full;
  logic [15:0]        w_hdr_cols;
  logic               w_start;
  logic               w_has_empty;
  logic               w_sel_bank;
  logic [2:0]         w_shift;
  logic [OUT_W-1:0]   w_wdata;
  logic               w_col_load;
  logic               w_col_bank;
  logic               w_fill_done;
  logic               w_we;
  logic [LINE_AW:0]   w_waddr;

  logic               w_pick;
  logic               w_rd_start;
  logic               w_streaming;
  logic               w_out_load;
  logic               w_q_take;
  logic               w_fetch;
  logic               w_re;
  logic [LINE_AW:0]   w_raddr;
  logic               w_free;
  logic [OUT_W-1:0]   w_hdr_word;
  logic [OUT_W-1:0]   w_rdata;

  // -------------------------------------------------------------------------
  // Per-bank state: full flag (set by the writer on the last sample, cleared
  // by the reader on acceptance of the last word) and the column header.
  // A bank is only ever selected for writing while its full flag is clear,
  // so the reader and writer never touch the same bank.
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      logic       r_full;
      logic [7:0] r_col;

      always_ff @(posedge ClockFromGen) begin
        if (Reset) begin
          r_full <= 1'b0;
          r_col  <= '0;
        end else begin
          if (w_fill_done && (r_wr_bank == 1'(gi))) begin
            r_full <= 1'b1;
          end else if (w_free && (r_rd_bank == 1'(gi))) begin
            r_full <= 1'b0;
          end
          if (w_col_load && (w_col_bank == 1'(gi))) r_col <= ColumnIn;
        end
      end

      assign w_full[gi]            = r_full;
      assign w_hdr_cols[gi*8 +: 8] = r_col;
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Write side
  // -------------------------------------------------------------------------
  assign w_start     = LineStart & DataAccStrobe;
  assign w_has_empty = ~&w_full;
  assign w_sel_bank  = w_full[0];          // bank 0 if free, otherwise bank 1
  // sample 0 must use the shift of the line it starts, not the previous one
  assign w_shift     = w_start ? iter_shift(IterCount) : r_shift;
  assign w_wdata     = norm_sat(DataAccIn, w_shift);

  // a new line is taken either from idle into a free bank, or as a restart
  // of the bank currently being filled
  assign w_col_load  = w_start & ((r_wstate == W_FILL) | w_has_empty);
  assign w_col_bank  = (r_wstate == W_FILL) ? r_wr_bank : w_sel_bank;
  assign w_fill_done = (r_wstate == W_FILL) & ~w_start & DataAccStrobe &
                       (r_wr_addr == LAST_ADDR);

  assign w_we    = w_col_load | ((r_wstate == W_FILL) & DataAccStrobe);
  assign w_waddr = w_col_load ? {w_col_bank, {LINE_AW{1'b0}}}
                              : {r_wr_bank, r_wr_addr};

  always_ff @(posedge ClockFromGen) begin
    if (Reset) begin
      r_wstate     <= W_IDLE;
      r_wr_addr    <= '0;
      r_wr_bank    <= 1'b0;
      r_shift      <= '0;
      r_drop_cnt   <= '0;
      r_trunc_cnt  <= '0;
      r_newer_bank <= 1'b0;
    end else begin
      if (w_col_load) begin
        r_wr_bank <= w_col_bank;
        r_shift   <= w_shift;
        r_wr_addr <= LINE_AW'(1);
        r_wstate  <= W_FILL;
      end else if ((r_wstate == W_FILL) && DataAccStrobe) begin
        r_wr_addr <= r_wr_addr + 1'b1;
        if (w_fill_done) begin
          r_wstate     <= W_IDLE;
          r_newer_bank <= r_wr_bank;
        end
      end

      if (w_start && (r_wstate == W_IDLE) && !w_has_empty && (r_drop_cnt != 8'hFF))
        r_drop_cnt <= r_drop_cnt + 1'b1;
      if (w_start && (r_wstate == W_FILL) && (r_trunc_cnt != 8'hFF))
        r_trunc_cnt <= r_trunc_cnt + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Read side. Sample 0 is prefetched while the header is loaded, and a new
  // fetch is issued whenever the RAM read register is empty or being moved
  // into the output register, so a ready-high sink sees one word per cycle.
  // -------------------------------------------------------------------------
  assign w_pick      = (&w_full) ? ~r_newer_bank : w_full[1];
  assign w_rd_start  = (r_rstate == R_IDLE) & (|w_full);
  assign w_streaming = (r_rstate != R_IDLE);
  assign w_out_load  = ~r_out_valid | OutReady;
  assign w_q_take    = w_streaming & w_out_load & r_q_valid;
  assign w_fetch     = w_streaming & ~r_rd_addr[LINE_AW] & (~r_q_valid | w_q_take);
  assign w_re        = w_rd_start | w_fetch;
  assign w_raddr     = w_rd_start ? {w_pick, {LINE_AW{1'b0}}}
                                  : {r_rd_bank, r_rd_addr[LINE_AW-1:0]};
  assign w_free      = (r_rstate == R_DATA) & r_out_valid & OutReady & r_out_last;
  assign w_hdr_word  = {HDR_MARK, (w_pick ? w_hdr_cols[15:8] : w_hdr_cols[7:0])};

  always_ff @(posedge ClockFromGen) begin
    if (Reset) begin
      r_rstate    <= R_IDLE;
      r_rd_bank   <= 1'b0;
      r_rd_addr   <= '0;
      r_q_valid   <= 1'b0;
      r_q_last    <= 1'b0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_first <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      if (w_re) begin
        r_q_valid <= 1'b1;
        r_q_last  <= (w_raddr[LINE_AW-1:0] == LAST_ADDR);
        r_rd_addr <= w_rd_start ? (LINE_AW+1)'(1) : r_rd_addr + 1'b1;
      end else if (w_q_take) begin
        r_q_valid <= 1'b0;
      end

      case (r_rstate)
        R_IDLE: begin
          if (w_rd_start) begin
            r_rd_bank   <= w_pick;
            r_out_data  <= w_hdr_word;
            r_out_valid <= 1'b1;
            r_out_first <= 1'b1;
            r_out_last  <= 1'b0;
            r_rstate    <= R_HDR;
          end
        end
        R_HDR, R_DATA: begin
          if (w_out_load) begin
            r_out_first <= 1'b0;
            if (r_q_valid) begin
              r_out_data  <= w_rdata;
              r_out_valid <= 1'b1;
              r_out_last  <= r_q_last;
            end else begin
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
            end
            if (r_rstate == R_HDR) r_rstate <= R_DATA;
          end
          if (w_free) r_rstate <= R_IDLE;
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  line_bank_ram #(
    .AW (LINE_AW + 1),
    .W  (OUT_W)
  ) u_ram (
    .i_clk   (ClockFromGen),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (w_re),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  assign OutData    = r_out_data;
  assign OutValid   = r_out_valid;
  assign OutFirst   = r_out_first;
  assign OutLast    = r_out_last;
  assign DropCount  = r_drop_cnt;
  assign TruncCount = r_trunc_cnt;

endmodule
